// File: rtl/riscv_mem_pkg.sv
// riscv_mem_pkg: funct3 codes, LSU state encoding and access-size helpers
package riscv_mem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    typedef enum logic [2:0] {IDLE, ACC0, ACC1, CAP, RESP} state_t;

    function automatic logic f3_illegal(input logic we, input logic [2:0] f3);
        return !(f3 inside {F3_B, F3_H, F3_W, F3_BU, F3_HU}) || (we && f3[2]);
    endfunction

    function automatic logic [3:0] size_mask(input logic [2:0] f3);
        return (f3[1:0] == 2'b00) ? 4'b0001 : (f3[1:0] == 2'b01) ? 4'b0011 : 4'b1111;
    endfunction
endpackage

// File: rtl/lsu_align.sv
// lsu_align: byte-lane alignment of store data/enables and extraction/extension of load data
module lsu_align
    import riscv_mem_pkg::*;
(
    input  logic        i_we,
    input  logic [2:0]  i_funct3,
    input  logic [1:0]  i_off,
    input  logic [31:0] i_wdata,
    input  logic [31:0] i_lo_word,
    input  logic [31:0] i_hi_word,
    output logic [3:0]  o_lo_be,
    output logic [3:0]  o_hi_be,
    output logic [31:0] o_lo_wdata,
    output logic [31:0] o_hi_wdata,
    output logic        o_split,
    output logic        o_illegal,
    output logic [31:0] o_ext_data
);
    logic [7:0]  w_mask;
    logic [63:0] w_wide;
    logic [31:0] w_rd;
    logic        w_sx;

    assign w_mask     = {4'b0000, size_mask(i_funct3)} << i_off;
    assign o_lo_be    = w_mask[3:0];
    assign o_hi_be    = w_mask[7:4];
    assign o_split    = |w_mask[7:4];
    assign o_illegal  = f3_illegal(i_we, i_funct3);
    assign w_wide     = {32'b0, i_wdata} << {i_off, 3'b000};
    assign o_lo_wdata = w_wide[31:0];
    assign o_hi_wdata = w_wide[63:32];
    assign w_rd       = 32'({i_hi_word, i_lo_word} >> {i_off, 3'b000});
    assign w_sx       = ~i_funct3[2];
    assign o_ext_data = (i_funct3[1:0] == 2'b00) ? {{24{w_sx & w_rd[7]}}, w_rd[7:0]} :
                        (i_funct3[1:0] == 2'b01) ? {{16{w_sx & w_rd[15]}}, w_rd[15:0]} : w_rd;
endmodule

// File: rtl/load_store_unit.sv
// load_store_unit: RV32 load/store initiator that splits word-crossing accesses into two memory beats
module load_store_unit
    import riscv_mem_pkg::*;
#(
    parameter int AW = 12
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_req_valid,
    output logic          o_req_ready,
    input  logic          i_req_we,
    input  logic [2:0]    i_req_funct3,
    input  logic [31:0]   i_req_addr,
    input  logic [31:0]   i_req_wdata,
    output logic          o_rsp_valid,
    output logic [31:0]   o_rsp_rdata,
    output logic          o_rsp_err,
    output logic          o_mem_en,
    output logic          o_mem_we,
    output logic [AW-1:0] o_mem_addr,
    output logic [3:0]    o_mem_be,
    output logic [31:0]   o_mem_wdata,
    input  logic [31:0]   i_mem_rdata
);
    state_t          r_state, w_next;
    logic            r_we;
    logic [2:0]      r_funct3;
    logic [AW+1:0]   r_addr;
    logic [31:0]     r_wdata, r_lo_buf;
    logic            w_idle, w_we;
    logic [2:0]      w_f3;
    logic [AW+1:0]   w_addr;
    logic [AW-1:0]   w_k;
    logic [31:0]     w_wdata, w_lo_word, w_hi_word;
    logic [3:0]      w_lo_be, w_hi_be;
    logic [31:0]     w_lo_wdata, w_hi_wdata, w_ext;
    logic            w_split, w_illegal;
    logic            w_mem_en, w_mem_we;
    logic [AW-1:0]   w_mem_addr;
    logic [3:0]      w_mem_be;
    logic [31:0]     w_mem_wdata;
    logic            w_unused;

    assign w_unused    = ^i_req_addr[31:AW+2];
    assign w_idle      = (r_state == IDLE);
    assign o_req_ready = w_idle;
    // In IDLE the decoder looks at the incoming request so ACC0 outputs can be registered on accept
    assign w_we        = w_idle ? i_req_we : r_we;
    assign w_f3        = w_idle ? i_req_funct3 : r_funct3;
    assign w_addr      = w_idle ? i_req_addr[AW+1:0] : r_addr;
    assign w_wdata     = w_idle ? i_req_wdata : r_wdata;
    assign w_k         = w_addr[AW+1:2];
    assign w_lo_word   = w_split ? r_lo_buf : i_mem_rdata;
    assign w_hi_word   = w_split ? i_mem_rdata : 32'b0;

    lsu_align u_align (
        .i_we       (w_we),
        .i_funct3   (w_f3),
        .i_off      (w_addr[1:0]),
        .i_wdata    (w_wdata),
        .i_lo_word  (w_lo_word),
        .i_hi_word  (w_hi_word),
        .o_lo_be    (w_lo_be),
        .o_hi_be    (w_hi_be),
        .o_lo_wdata (w_lo_wdata),
        .o_hi_wdata (w_hi_wdata),
        .o_split    (w_split),
        .o_illegal  (w_illegal),
        .o_ext_data (w_ext)
    );

    always_comb begin
        w_next      = r_state;
        w_mem_en    = 1'b0;
        w_mem_we    = 1'b0;
        w_mem_addr  = '0;
        w_mem_be    = '0;
        w_mem_wdata = '0;
        case (r_state)
            IDLE: if (i_req_valid) begin
                w_next      = w_illegal ? RESP : ACC0;
                w_mem_en    = !w_illegal;
                w_mem_we    = !w_illegal && i_req_we;
                w_mem_addr  = w_illegal ? '0 : w_k;
                w_mem_be    = w_illegal ? 4'b0000 : w_lo_be;
                w_mem_wdata = w_mem_we ? w_lo_wdata : 32'b0;
            end
            ACC0: begin
                w_next      = w_split ? ACC1 : (r_we ? RESP : CAP);
                w_mem_en    = w_split;
                w_mem_we    = w_split && r_we;
                w_mem_addr  = w_split ? w_k + AW'(1) : '0;
                w_mem_be    = w_split ? w_hi_be : 4'b0000;
                w_mem_wdata = w_mem_we ? w_hi_wdata : 32'b0;
            end
            ACC1:    w_next = r_we ? RESP : CAP;
            CAP:     w_next = RESP;
            RESP:    w_next = IDLE;
            default: w_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_we        <= 1'b0;
            r_funct3    <= '0;
            r_addr      <= '0;
            r_wdata     <= '0;
            r_lo_buf    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_rdata <= '0;
            o_rsp_err   <= 1'b0;
            o_mem_en    <= 1'b0;
            o_mem_we    <= 1'b0;
            o_mem_addr  <= '0;
            o_mem_be    <= '0;
            o_mem_wdata <= '0;
        end else begin
            r_state     <= w_next;
            o_mem_en    <= w_mem_en;
            o_mem_we    <= w_mem_we;
            o_mem_addr  <= w_mem_addr;
            o_mem_be    <= w_mem_be;
            o_mem_wdata <= w_mem_wdata;
            o_rsp_valid <= (w_next == RESP);
            if (w_idle && i_req_valid) begin
                r_we     <= i_req_we;
                r_funct3 <= i_req_funct3;
                r_addr   <= i_req_addr[AW+1:0];
                r_wdata  <= i_req_wdata;
            end
            if (r_state == ACC1)
                r_lo_buf <= i_mem_rdata;
            if (w_next == RESP) begin
                o_rsp_rdata <= (r_state == CAP) ? w_ext : 32'b0;
                o_rsp_err   <= w_idle;
            end
        end
    end
endmodule
